// File: rtl/if_stage.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited imem requests,
// buffers up to two fetched instructions and handles redirects. Macro IF_PERF_CNT_EN adds perf counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    logic [31:0] pc;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        fifo_head;
    logic        fifo_tail;
    logic [1:0]  fifo_count;
    logic [31:0] pend_pc [2];
    logic        pend_head;
    logic        pend_tail;
    logic [1:0]  outstanding;
    logic [1:0]  drop;
    logic [31:0] held_pc;

    logic        pop;
    logic        accept;
    logic        rsp_take;
    logic        rsp_keep;
    logic [2:0]  credit_used;

    always_comb begin
        if_valid    = (fifo_count != 2'd0);
        if_instr    = if_valid ? fifo_instr[fifo_head] : NOP_INSTR;
        if_pc       = if_valid ? fifo_pc[fifo_head] : held_pc;
        pop         = if_valid && !id_stall;
        // A head leaving this cycle frees its slot, which keeps 1-cycle memory at full rate.
        credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
        imem_req_valid = !rst && (drop == 2'd0) && !redirect_valid && (credit_used < 3'd2);
        imem_req_addr  = pc;
        accept   = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding are leftovers from before a reset.
        rsp_take = imem_rsp_valid && (outstanding != 2'd0);
        rsp_keep = rsp_take && (drop == 2'd0) && !redirect_valid;
    end

    // NOTE: payload storage has no reset; validity lives entirely in the pointers and counts.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_pc[pend_tail] <= pc;
        end
        if (rsp_keep) begin
            fifo_instr[fifo_tail] <= imem_rsp_data;
            fifo_pc[fifo_tail]    <= pend_pc[pend_head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            fifo_head   <= 1'b0;
            fifo_tail   <= 1'b0;
            fifo_count  <= 2'd0;
            pend_head   <= 1'b0;
            pend_tail   <= 1'b0;
            outstanding <= 2'd0;
            drop        <= 2'd0;
            held_pc     <= 32'h0000_0000;
        end else begin
            held_pc <= if_pc;
            if (redirect_valid) begin
                // Every request still in flight, minus one answered now, must be discarded.
                pc          <= redirect_target & 32'hFFFF_FFFC;
                fifo_head   <= 1'b0;
                fifo_tail   <= 1'b0;
                fifo_count  <= 2'd0;
                pend_head   <= 1'b0;
                pend_tail   <= 1'b0;
                outstanding <= outstanding - {1'b0, rsp_take};
                drop        <= outstanding - {1'b0, rsp_take};
            end else begin
                if (accept) begin
                    pc        <= pc + 32'd4;
                    pend_tail <= ~pend_tail;
                end
                if (rsp_keep) begin
                    pend_head <= ~pend_head;
                    fifo_tail <= ~fifo_tail;
                end
                if (pop) begin
                    fifo_head <= ~fifo_head;
                end
                fifo_count  <= fifo_count + {1'b0, rsp_keep} - {1'b0, pop};
                outstanding <= outstanding + {1'b0, accept} - {1'b0, rsp_take};
                if (rsp_take && (drop != 2'd0)) begin
                    drop <= drop - 2'd1;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0000_0000;
            perf_flush_cnt <= 32'h0000_0000;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
